// File: rtl/hpdmc_ddr_pkg.sv
// rtl/hpdmc_ddr_pkg.sv - shared types and sizing helpers for the HPDMC DDR data path
package hpdmc_ddr_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_PRE  = 2'd1,
      W_DATA = 2'd2,
      W_POST = 2'd3
   } wstate_e;

   function automatic int lanes(input int dq_w);
      return dq_w / 8;
   endfunction

   function automatic int beats(input int bl);
      return bl / 2;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Extra MSB is the wrap bit that separates full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/hpdmc_ddr_fifo.sv
// rtl/hpdmc_ddr_fifo.sv - synchronous FIFO with combinational head, DEPTH a power of 2 >= 2
module hpdmc_ddr_fifo
   import hpdmc_ddr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);
   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign wr_ptr_d = wr_ptr_q + PW'(do_push);
   assign rd_ptr_d = rd_ptr_q + PW'(do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end

endmodule

// File: rtl/hpdmc_ddr_datapath.sv
// rtl/hpdmc_ddr_datapath.sv - DDR SDRAM data path: write FIFO to ODDR with DQS pre/postamble,
// IDDR capture after a fixed CAS latency into a read FIFO
module hpdmc_ddr_datapath
   import hpdmc_ddr_pkg::*;
#(
   parameter int  DQ_W     = 32,
   parameter int  BL       = 4,
   parameter int  WF_DEPTH = 8,
   parameter int  RF_DEPTH = 8,
   parameter int  RD_LAT   = 5,
   localparam int L        = lanes(DQ_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [2*DQ_W-1:0] wr_dat,
   input  logic [2*L-1:0]    wr_mask,
   input  logic              op_write,
   input  logic              op_read,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [2*DQ_W-1:0] rd_dat,
   output logic [DQ_W-1:0]   phy_dq_r,
   output logic [DQ_W-1:0]   phy_dq_f,
   output logic [L-1:0]      phy_dqm_r,
   output logic [L-1:0]      phy_dqm_f,
   output logic              phy_dq_oe,
   output logic              phy_dqs_oe,
   input  logic [DQ_W-1:0]   phy_dq_in_r,
   input  logic [DQ_W-1:0]   phy_dq_in_f,
   output logic              err_underrun,
   output logic              err_overflow,
   output logic              err_protocol
);
   localparam int BEATS = beats(BL);
   localparam int CW    = cnt_w(BEATS);
   localparam int WW    = 2*DQ_W + 2*L;
   localparam int SRW   = RD_LAT + BEATS - 1;

   wstate_e        state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [SRW-1:0] rd_sr_q, rd_sr_d;
   logic           err_underrun_q, err_underrun_d;
   logic           err_overflow_q, err_overflow_d;
   logic           err_protocol_q, err_protocol_d;

   logic           wf_pop, wf_full, wf_empty;
   logic [WW-1:0]  wf_head;
   logic           rf_full, rf_empty;
   logic           rd_capture;

   hpdmc_ddr_fifo #(
      .WIDTH (WW),
      .DEPTH (WF_DEPTH)
   ) u_wfifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (wr_valid),
      .push_dat_i ({wr_dat, wr_mask}),
      .pop_i      (wf_pop),
      .full_o     (wf_full),
      .empty_o    (wf_empty),
      .head_o     (wf_head)
   );

   hpdmc_ddr_fifo #(
      .WIDTH (2*DQ_W),
      .DEPTH (RF_DEPTH)
   ) u_rfifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (rd_capture),
      .push_dat_i ({phy_dq_in_r, phy_dq_in_f}),
      .pop_i      (rd_ready),
      .full_o     (rf_full),
      .empty_o    (rf_empty),
      .head_o     (rd_dat)
   );

   assign wr_ready = ~wf_full;
   assign rd_valid = ~rf_empty;

   // Bit i set means an op_read happened i+1 cycles ago; overlapping windows simply OR together.
   generate
      if (SRW == 1) begin : g_sr_one
         assign rd_sr_d = op_read;
      end else begin : g_sr_many
         assign rd_sr_d = {rd_sr_q[SRW-2:0], op_read};
      end
   endgenerate

   assign rd_capture     = |rd_sr_q[SRW-1:RD_LAT-1];
   assign err_overflow_d = err_overflow_q | (rd_capture & rf_full & ~rd_ready);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      wf_pop         = 1'b0;
      err_underrun_d = err_underrun_q;
      err_protocol_d = err_protocol_q;
      phy_dq_oe      = 1'b0;
      phy_dqs_oe     = 1'b0;
      phy_dq_r       = '0;
      phy_dq_f       = '0;
      phy_dqm_r      = '1;
      phy_dqm_f      = '1;

      case (state_q)
         W_IDLE: begin
            if (op_write) begin
               state_d = W_PRE;
            end
         end
         W_PRE: begin
            phy_dqs_oe = 1'b1;
            cnt_d      = '0;
            state_d    = W_DATA;
            if (op_write) begin
               err_protocol_d = 1'b1;
            end
         end
         W_DATA: begin
            phy_dq_oe  = 1'b1;
            phy_dqs_oe = 1'b1;
            if (wf_empty) begin
               err_underrun_d = 1'b1;
            end else begin
               wf_pop = 1'b1;
               {phy_dq_r, phy_dq_f, phy_dqm_r, phy_dqm_f} = wf_head;
            end
            // Only an op_write on the last beat chains a seamless burst.
            if (cnt_q == CW'(BEATS-1)) begin
               cnt_d   = '0;
               state_d = op_write ? W_DATA : W_POST;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (op_write) begin
                  err_protocol_d = 1'b1;
               end
            end
         end
         W_POST: begin
            phy_dqs_oe = 1'b1;
            state_d    = W_IDLE;
            if (op_write) begin
               err_protocol_d = 1'b1;
            end
         end
         default: begin
            state_d = W_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= W_IDLE;
         cnt_q          <= '0;
         rd_sr_q        <= '0;
         err_underrun_q <= 1'b0;
         err_overflow_q <= 1'b0;
         err_protocol_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rd_sr_q        <= rd_sr_d;
         err_underrun_q <= err_underrun_d;
         err_overflow_q <= err_overflow_d;
         err_protocol_q <= err_protocol_d;
      end
   end

   assign err_underrun = err_underrun_q;
   assign err_overflow = err_overflow_q;
   assign err_protocol = err_protocol_q;

endmodule
